// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter that shares one single-port SRAM-style memory port
//   between NUM_REQ requesters. Requests are granted combinationally in the
//   cycle they are presented. The index of each granted read is recorded in
//   a small FIFO so that in-order memory responses can be routed back to the
//   requester that issued them.
//
// Ports
//   clk_i, srst_i        clock, synchronous active-high reset
//   req_i/we_i           per-requester request and write enable
//   addr_i/wdata_i/strb_i packed per-requester request fields
//   gnt_o                one-hot grant (request accepted this cycle)
//   rvalid_o, rdata_o    one-hot read-response valid, shared read data
//   mem_*_o              request side of the memory port
//   mem_rvalid_i/rdata_i in-order read responses from memory
//   busy_o               a read is outstanding
//   err_o                sticky: a response arrived with no read outstanding
module mem_port_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int MEM_AW          = 12,
    parameter int MEM_DW          = 64,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                        clk_i,
    input  logic                        srst_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          we_i,
    input  logic [NUM_REQ*MEM_AW-1:0]   addr_i,
    input  logic [NUM_REQ*MEM_DW-1:0]   wdata_i,
    input  logic [NUM_REQ*MEM_DW/8-1:0] strb_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [NUM_REQ-1:0]          rvalid_o,
    output logic [MEM_DW-1:0]           rdata_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [MEM_AW-1:0]           mem_addr_o,
    output logic [MEM_DW-1:0]           mem_wdata_o,
    output logic [MEM_DW/8-1:0]         mem_strb_o,
    input  logic                        mem_rvalid_i,
    input  logic [MEM_DW-1:0]           mem_rdata_i,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int SW = MEM_DW / 8;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [IW-1:0]      r_rr_ptr;
    logic [IW-1:0]      r_fifo [MAX_OUTSTANDING];
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic               r_err;

    logic               w_full;
    logic [NUM_REQ-1:0] w_elig;
    logic               w_found;
    logic [IW-1:0]      w_win;
    logic               w_push;
    logic               w_pop;
    logic [IW-1:0]      w_head;

    // Fullness looks only at the registered count, so a response arriving
    // this cycle cannot open a read slot combinationally.
    assign w_full = (r_count == CW'(MAX_OUTSTANDING));

    always_comb begin
        w_elig = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_elig[k] = !srst_i && req_i[k] && (we_i[k] || !w_full);
        end
    end

    // First eligible requester, searching upward from r_rr_ptr with wrap.
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_idx = int'(r_rr_ptr) + i;
            if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
            if (!w_found && w_elig[v_idx]) begin
                w_found = 1'b1;
                w_win   = IW'(v_idx);
            end
        end
    end

    // Grant and memory-side mux; data outputs are zero when nothing wins.
    always_comb begin
        gnt_o       = '0;
        mem_req_o   = w_found;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_strb_o  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_found && (w_win == IW'(k))) begin
                gnt_o[k]    = 1'b1;
                mem_we_o    = we_i[k];
                mem_addr_o  = addr_i[k*MEM_AW +: MEM_AW];
                mem_wdata_o = wdata_i[k*MEM_DW +: MEM_DW];
                mem_strb_o  = strb_i[k*SW +: SW];
            end
        end
    end

    assign w_push = w_found && !mem_we_o;
    assign w_pop  = !srst_i && mem_rvalid_i && (r_count != '0);
    assign w_head = r_fifo[r_rptr];

    always_comb begin
        rvalid_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rvalid_o[k] = w_pop && (w_head == IW'(k));
        end
    end

    assign rdata_o = mem_rdata_i;
    assign busy_o  = (r_count != '0);
    assign err_o   = r_err;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_rr_ptr <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_found) begin
                r_rr_ptr <= (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
            end
            if (w_push) begin
                r_wptr <= (r_wptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Response with nothing outstanding is dropped and flagged.
            if (mem_rvalid_i && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Index storage needs no reset: entries are only read after a push.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_win;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int MO = 2;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              srst;
    logic [N-1:0]      req, we;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N*SW-1:0]   strb;
    logic [N-1:0]      gnt, rvalid;
    logic [DW-1:0]     rdata;
    logic              mem_req, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [SW-1:0]     mem_strb;
    logic              mem_rvalid;
    logic [DW-1:0]     mem_rdata;
    logic              busy, err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_REQ(N), .MEM_AW(AW), .MEM_DW(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk), .srst_i(srst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .strb_i(strb), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .busy_o(busy),
        .err_o(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        srst = 1'b1; req = '0; we = '0;
        addr  = {12'h102, 12'h101, 12'h100};
        wdata = {64'hA2, 64'hA1, 64'hA0};
        strb  = {8'h0F, 8'hF0, 8'hFF};
        mem_rvalid = 1'b0; mem_rdata = '0;
        nxt();

        // Reset holds off grants even with everyone requesting.
        req = 3'b111; we = 3'b111; #1;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_memreq", 64'(mem_req), 64'h0);
        nxt();
        srst = 1'b0; req = '0; #1;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("idle_memreq", 64'(mem_req), 64'h0);

        // Continuous writes from all three: 001,010,100,001.
        req = 3'b111; we = 3'b111; #1;
        chk("wr0_gnt", 64'(gnt), 64'h1);
        chk("wr0_addr", 64'(mem_addr), 64'h100);
        chk("wr0_we", 64'(mem_we), 64'h1);
        chk("wr0_strb", 64'(mem_strb), 64'hFF);
        nxt(); #1;
        chk("wr1_gnt", 64'(gnt), 64'h2);
        chk("wr1_addr", 64'(mem_addr), 64'h101);
        chk("wr1_wdata", mem_wdata, 64'hA1);
        nxt(); #1;
        chk("wr2_gnt", 64'(gnt), 64'h4);
        chk("wr2_addr", 64'(mem_addr), 64'h102);
        chk("wr2_strb", 64'(mem_strb), 64'h0F);
        nxt(); #1;
        chk("wr3_gnt", 64'(gnt), 64'h1);
        chk("wr3_addr", 64'(mem_addr), 64'h100);
        nxt();                                  // rr_ptr now 1

        // Single read by req0, latency 1.
        req = 3'b001; we = 3'b000; addr = {12'h102, 12'h101, 12'h010}; #1;
        chk("rd_gnt", 64'(gnt), 64'h1);
        chk("rd_we", 64'(mem_we), 64'h0);
        chk("rd_addr", 64'(mem_addr), 64'h010);
        nxt();
        req = '0; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD; #1;
        chk("rd_rvalid", 64'(rvalid), 64'h1);
        chk("rd_rdata", rdata, 64'hDEAD);
        chk("rd_busy1", 64'(busy), 64'h1);
        nxt();
        mem_rvalid = 1'b0; #1;
        chk("rd_busy2", 64'(busy), 64'h0);
        chk("rd_rvalid_off", 64'(rvalid), 64'h0);
        chk("rd_err", 64'(err), 64'h0);

        // req1, req2 read continuously; latency 4, two outstanding max.
        req = 3'b110; we = 3'b000; #1;          // cycle A (rr_ptr 1)
        chk("mo_A_gnt", 64'(gnt), 64'h2);
        nxt(); #1;                              // B
        chk("mo_B_gnt", 64'(gnt), 64'h4);
        nxt(); #1;                              // C: full
        chk("mo_C_gnt", 64'(gnt), 64'h0);
        chk("mo_C_busy", 64'(busy), 64'h1);
        nxt(); #1;                              // D
        chk("mo_D_gnt", 64'(gnt), 64'h0);
        nxt();                                  // E: first response
        mem_rvalid = 1'b1; mem_rdata = 64'h1111; #1;
        chk("mo_E_gnt", 64'(gnt), 64'h0);
        chk("mo_E_rvalid", 64'(rvalid), 64'h2);
        nxt();                                  // F: second response
        mem_rdata = 64'h2222; #1;
        chk("mo_F_gnt", 64'(gnt), 64'h2);
        chk("mo_F_rvalid", 64'(rvalid), 64'h4);
        chk("mo_F_rdata", rdata, 64'h2222);
        nxt();
        req = '0; mem_rvalid = 1'b0; #1;
        chk("mo_G_busy", 64'(busy), 64'h1);
        nxt(); nxt(); nxt();                    // J = F+4
        mem_rvalid = 1'b1; mem_rdata = 64'h3333; #1;
        chk("mo_J_rvalid", 64'(rvalid), 64'h2);
        nxt();
        mem_rvalid = 1'b0; #1;
        chk("mo_done_busy", 64'(busy), 64'h0);

        // Fill the FIFO with req1 reads (rr_ptr 2).
        req = 3'b010; we = 3'b000; #1;
        chk("fl_rd0_gnt", 64'(gnt), 64'h2);
        nxt(); #1;
        chk("fl_rd1_gnt", 64'(gnt), 64'h2);
        nxt();
        // Full: req0 writes keep going, req1 read waits.
        req = 3'b011; we = 3'b001; #1;
        chk("fl_w0_gnt", 64'(gnt), 64'h1);
        nxt(); #1;
        chk("fl_w1_gnt", 64'(gnt), 64'h1);
        nxt();
        mem_rvalid = 1'b1; #1;                  // pop does not unblock this cycle
        chk("fl_w2_gnt", 64'(gnt), 64'h1);
        chk("fl_w2_rvalid", 64'(rvalid), 64'h2);
        nxt();
        mem_rvalid = 1'b0; #1;                  // count 1, rr_ptr 1
        chk("fl_rd2_gnt", 64'(gnt), 64'h2);
        nxt();
        req = '0; #1;
        chk("fl_busy", 64'(busy), 64'h1);

        // Reset with two reads outstanding.
        srst = 1'b1; req = 3'b111; we = 3'b111; #1;
        chk("rs_gnt", 64'(gnt), 64'h0);
        chk("rs_memreq", 64'(mem_req), 64'h0);
        nxt();
        srst = 1'b0; #1;
        chk("rs_busy", 64'(busy), 64'h0);
        chk("rs_tie_gnt", 64'(gnt), 64'h1);
        nxt();
        // Late response after reset is spurious.
        req = '0; mem_rvalid = 1'b1; mem_rdata = 64'h4444; #1;
        chk("sp_rvalid", 64'(rvalid), 64'h0);
        chk("sp_err_pre", 64'(err), 64'h0);
        nxt();
        mem_rvalid = 1'b0; #1;
        chk("sp_err_set", 64'(err), 64'h1);
        nxt(); nxt(); #1;
        chk("sp_err_sticky", 64'(err), 64'h1);
        srst = 1'b1;
        nxt();
        srst = 1'b0; #1;
        chk("sp_err_clr", 64'(err), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
